// File: rtl/comparador_canales.sv
// rtl/comparador_canales.sv - multi-channel counter comparator with double-buffered thresholds
// Per-channel level, one-cycle rising pulse and sticky flag; oAny ORs the sticky flags.
module comparador_canales #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      iClk,
    input  logic                      iReset,
    input  logic [WIDTH-1:0]          ivCuenta,
    input  logic [CHANNELS*WIDTH-1:0] ivCompareValues,
    input  logic                      iLoad,
    input  logic                      iUpdate,
    input  logic [2*CHANNELS-1:0]     ivMode,
    input  logic [CHANNELS-1:0]       ivClear,
    output logic [CHANNELS-1:0]       ovLevel,
    output logic [CHANNELS-1:0]       ovPulse,
    output logic [CHANNELS-1:0]       ovSticky,
    output logic                      oAny
);

    logic [WIDTH-1:0]    shadowQ [CHANNELS];
    logic [WIDTH-1:0]    activeQ [CHANNELS];
    logic [CHANNELS-1:0] vCompare;
    logic [CHANNELS-1:0] vRise;

    // Load together with update bypasses the new value straight into active.
    always_ff @(posedge iClk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (iReset) begin
                shadowQ[i] <= '0;
                activeQ[i] <= '0;
            end else begin
                if (iLoad) begin
                    shadowQ[i] <= ivCompareValues[i*WIDTH +: WIDTH];
                end
                if (iLoad && iUpdate) begin
                    activeQ[i] <= ivCompareValues[i*WIDTH +: WIDTH];
                end else if (iUpdate) begin
                    activeQ[i] <= shadowQ[i];
                end
            end
        end
    end

    always_comb begin
        vCompare = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (ivMode[2*i +: 2])
                2'b00:   vCompare[i] = (ivCuenta == activeQ[i]);
                2'b01:   vCompare[i] = (ivCuenta >= activeQ[i]);
                2'b10:   vCompare[i] = (ivCuenta <  activeQ[i]);
                default: vCompare[i] = 1'b0;
            endcase
        end
    end

    assign vRise = vCompare & ~ovLevel;

    // A new rising edge beats a simultaneous clear.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            ovLevel  <= '0;
            ovPulse  <= '0;
            ovSticky <= '0;
        end else begin
            ovLevel  <= vCompare;
            ovPulse  <= vRise;
            ovSticky <= (ovSticky & ~ivClear) | vRise;
        end
    end

    assign oAny = |ovSticky;

endmodule

// File: tb/tb_comparador_canales.sv
// tb/tb_comparador_canales.sv - directed self-checking bench for comparador_canales
// Drives inputs 1 ns after each rising edge and checks outputs at that same point.
module tb_comparador_canales;

    logic        iClk = 1'b0;
    logic        iReset;
    logic [7:0]  ivCuenta;
    logic [31:0] ivCompareValues;
    logic        iLoad, iUpdate;
    logic [7:0]  ivMode;
    logic [3:0]  ivClear;
    logic [3:0]  ovLevel, ovPulse, ovSticky;
    logic        oAny;

    logic        pReset;
    logic [11:0] pCuenta;
    logic [23:0] pCompareValues;
    logic        pLoad, pUpdate;
    logic [3:0]  pMode;
    logic [1:0]  pClear;
    logic [1:0]  pLevel, pPulse, pSticky;
    logic        pAny;

    int checkCount = 0;
    int errorCount = 0;

    always #5 iClk = ~iClk;

    comparador_canales #(.WIDTH(8), .CHANNELS(4)) dut (
        .iClk(iClk), .iReset(iReset), .ivCuenta(ivCuenta),
        .ivCompareValues(ivCompareValues), .iLoad(iLoad), .iUpdate(iUpdate),
        .ivMode(ivMode), .ivClear(ivClear), .ovLevel(ovLevel),
        .ovPulse(ovPulse), .ovSticky(ovSticky), .oAny(oAny)
    );

    comparador_canales #(.WIDTH(12), .CHANNELS(2)) dutParam (
        .iClk(iClk), .iReset(pReset), .ivCuenta(pCuenta),
        .ivCompareValues(pCompareValues), .iLoad(pLoad), .iUpdate(pUpdate),
        .ivMode(pMode), .ivClear(pClear), .ovLevel(pLevel),
        .ovPulse(pPulse), .ovSticky(pSticky), .oAny(pAny)
    );

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    logic [3:0] expLevel, prevLevel, expPulse;
    int pulseAt [4];
    int pulseCnt [4];

    initial begin
        iReset = 1'b1; pReset = 1'b1;
        pCuenta = 12'hFFE; pCompareValues = '0; pLoad = 0; pUpdate = 0; pMode = 4'hF; pClear = '0;
        for (int k = 0; k < 2; k++) begin
            ivCuenta = 8'($urandom); ivCompareValues = $urandom; iLoad = 1'($urandom);
            iUpdate = 1'($urandom); ivMode = 8'($urandom); ivClear = 4'($urandom);
            tick();
        end
        chequear("rst_level", {28'b0, ovLevel}, 32'h0);
        chequear("rst_pulse", {28'b0, ovPulse}, 32'h0);
        chequear("rst_sticky", {28'b0, ovSticky}, 32'h0);
        chequear("rst_any", {31'b0, oAny}, 32'h0);
        chequear("rst_param", {26'b0, pLevel, pPulse, pSticky}, 32'h0);

        // Active is 0 after reset, so count 5 in equal mode never matches.
        iReset = 0; pReset = 0; iLoad = 0; iUpdate = 0; ivClear = 0;
        ivMode = 8'h00; ivCuenta = 8'h05; ivCompareValues = '0;
        tick();
        chequear("post_rst_level", {28'b0, ovLevel}, 32'h0);

        // Double buffering: shadow load alone does not affect compare.
        ivMode = 8'b11111100; ivCuenta = 8'h10; ivCompareValues = 32'h0000_0010; iLoad = 1;
        tick();
        iLoad = 0;
        tick();
        chequear("shadow_only_level0", {31'b0, ovLevel[0]}, 32'h0);
        iUpdate = 1;
        tick();
        iUpdate = 0;
        chequear("upd_edge_level0", {31'b0, ovLevel[0]}, 32'h0);
        tick();
        chequear("upd_level0", {31'b0, ovLevel[0]}, 32'h1);
        chequear("upd_pulse0", {31'b0, ovPulse[0]}, 32'h1);
        chequear("upd_sticky0", {31'b0, ovSticky[0]}, 32'h1);
        tick();
        chequear("held_pulse0", {31'b0, ovPulse[0]}, 32'h0);
        chequear("held_level0", {31'b0, ovLevel[0]}, 32'h1);

        // Modes sweep: all thresholds 0x80, modes eq/ge/lt/off.
        ivCompareValues = {4{8'h80}}; iLoad = 1; iUpdate = 1;
        ivMode = 8'b11_10_01_00; ivClear = 4'hF; ivCuenta = 8'hFF;
        tick();
        iLoad = 0; iUpdate = 0; ivClear = 0;
        prevLevel = 4'b0010;
        chequear("sweep_setup_level", {28'b0, ovLevel}, {28'b0, prevLevel});
        for (int c = 0; c < 4; c++) begin pulseAt[c] = -1; pulseCnt[c] = 0; end
        for (int c = 0; c < 256; c++) begin
            ivCuenta = 8'(c);
            tick();
            expLevel = {1'b0, (c < 128), (c >= 128), (c == 128)};
            expPulse = expLevel & ~prevLevel;
            chequear($sformatf("sweep_level_%02h", c), {28'b0, ovLevel}, {28'b0, expLevel});
            chequear($sformatf("sweep_pulse_%02h", c), {28'b0, ovPulse}, {28'b0, expPulse});
            for (int k = 0; k < 4; k++) begin
                if (ovPulse[k]) begin pulseAt[k] = c; pulseCnt[k]++; end
            end
            prevLevel = expLevel;
        end
        chequear("pulse_pos_ch0", pulseAt[0], 32'h80);
        chequear("pulse_pos_ch1", pulseAt[1], 32'h80);
        chequear("pulse_pos_ch2", pulseAt[2], 32'h00);
        chequear("pulse_cnt_ch0", pulseCnt[0], 32'h1);
        chequear("pulse_cnt_ch1", pulseCnt[1], 32'h1);
        chequear("pulse_cnt_ch2", pulseCnt[2], 32'h1);
        chequear("pulse_cnt_ch3", pulseCnt[3], 32'h0);

        // Sticky and clear.
        chequear("sticky1_set", {31'b0, ovSticky[1]}, 32'h1);
        chequear("any_set", {31'b0, oAny}, 32'h1);
        ivClear = 4'hF;
        tick();
        ivClear = 0;
        chequear("sticky_cleared", {28'b0, ovSticky}, 32'h0);
        chequear("any_cleared", {31'b0, oAny}, 32'h0);
        ivCuenta = 8'h00;
        tick();
        ivCuenta = 8'h80; ivClear = 4'b0010;
        tick();
        chequear("clr_vs_rise_sticky1", {31'b0, ovSticky[1]}, 32'h1);
        chequear("clr_vs_rise_pulse1", {31'b0, ovPulse[1]}, 32'h1);
        tick();
        ivClear = 0;
        chequear("clr_held_sticky1", {31'b0, ovSticky[1]}, 32'h0);

        // Simultaneous load and update on ch2.
        ivMode = 8'hCF; ivCompareValues = 32'h0033_0000; iLoad = 1; iUpdate = 1; ivCuenta = 8'h00;
        tick();
        iLoad = 0; iUpdate = 0; ivCuenta = 8'h33;
        tick();
        chequear("bypass_level2", {31'b0, ovLevel[2]}, 32'h1);
        chequear("bypass_pulse2", {31'b0, ovPulse[2]}, 32'h1);
        iUpdate = 1;
        tick();
        iUpdate = 0;
        tick();
        chequear("lone_upd_level2", {31'b0, ovLevel[2]}, 32'h1);
        chequear("lone_upd_pulse2", {31'b0, ovPulse[2]}, 32'h0);
        ivCompareValues = 32'h0044_0000; iLoad = 1;
        tick();
        iLoad = 0;
        tick();
        chequear("load_only_level2", {31'b0, ovLevel[2]}, 32'h1);

        // Disabling a channel drops level without a pulse; sticky kept.
        ivMode = 8'hFF;
        tick();
        chequear("off_level2", {31'b0, ovLevel[2]}, 32'h0);
        chequear("off_pulse2", {31'b0, ovPulse[2]}, 32'h0);
        chequear("off_sticky2", {31'b0, ovSticky[2]}, 32'h1);

        // Reset mid-operation, then equal mode at count 0 matches active=0.
        iReset = 1; pReset = 1;
        tick();
        chequear("mid_rst_sticky", {28'b0, ovSticky}, 32'h0);
        chequear("mid_rst_any", {31'b0, oAny}, 32'h0);
        iReset = 0; pReset = 0; ivMode = 8'h00; ivCuenta = 8'h00;
        tick();
        chequear("after_rst_level", {28'b0, ovLevel}, 32'hF);
        chequear("after_rst_pulse", {28'b0, ovPulse}, 32'hF);

        // 12-bit, 2-channel instance: wrap 0xFFF -> 0x000.
        pCompareValues = {12'h000, 12'hFFF}; pLoad = 1; pUpdate = 1; pMode = 4'h0; pCuenta = 12'hFFE;
        tick();
        pLoad = 0; pUpdate = 0; pCuenta = 12'hFFF;
        tick();
        chequear("param_pulse_fff", {30'b0, pPulse}, 32'h1);
        pCuenta = 12'h000;
        tick();
        chequear("param_pulse_000", {30'b0, pPulse}, 32'h2);
        chequear("param_any", {31'b0, pAny}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/comparador_canales.md
# comparador_canales

Multi-channel, parametrised successor to the 8-bit single-flag comparator. It compares the shared counter value against CHANNELS independent thresholds. Each channel has a selectable compare mode and double-buffered (shadow/active) thresholds. Per channel it produces a registered level flag, a one-cycle match pulse and a sticky flag with clear. It sits beside the 8-bit counter and feeds the PWM/timer-event logic; `iUpdate` is normally driven by the counter's wrap/overflow signal.

## Interface
- WIDTH, 8, bit width of the count and of each threshold
- CHANNELS, 4, number of compare channels (1..16)
- iClk  input  1  clock, all state updates on rising edge
- iReset  input  1  reset, synchronous, active-high
- ivCuenta  input  WIDTH  current counter value, shared by all channels
- ivCompareValues  input  CHANNELS*WIDTH  new thresholds; channel i at bits [i*WIDTH +: WIDTH]
- iLoad  input  1  writes ivCompareValues into the shadow registers
- iUpdate  input  1  transfers shadow to active thresholds
- ivMode  input  2*CHANNELS  per-channel mode at [2i +: 2]: 00 equal, 01 greater-or-equal, 10 less-than, 11 disabled
- ivClear  input  CHANNELS  per-channel sticky-flag clear
- ovLevel  output  CHANNELS  registered compare result
- ovPulse  output  CHANNELS  one-cycle pulse on a 0->1 transition of the level
- ovSticky  output  CHANNELS  latched match indication
- oAny  output  1  OR of all ovSticky bits

## Operation
- Per channel there are two registers, shadow[i] and active[i], each WIDTH bits. Compares always use active[i].
- Register updates:
  - iLoad alone: shadow <= ivCompareValues.
  - iUpdate alone: active <= shadow.
  - iLoad and iUpdate in the same cycle: shadow <= ivCompareValues and active <= ivCompareValues (new values bypass into active).
- Compare (combinational), d[i]:
  - mode 00: ivCuenta == active[i]
  - mode 01: ivCuenta >= active[i]
  - mode 10: ivCuenta < active[i]
  - mode 11: 0
  - Compares are unsigned, full WIDTH. No wrap handling is needed: the counter wrapping back to 0 simply re-evaluates.
- Flag registers:
  - Level: ovLevel[i] <= d[i].
  - Pulse: ovPulse[i] <= d[i] & ~ovLevel[i]. It is high only for the cycle in which ovLevel first rises.
  - Sticky: ovSticky[i] <= (ovSticky[i] & ~ivClear[i]) | (d[i] & ~ovLevel[i]).
  - Clear and a new rising edge in the same cycle: the set wins and sticky stays 1.
- oAny = |ovSticky. It is combinational from registers and glitch-free.
- ivMode is not buffered; a mode change takes effect on the next compare.
  - Switching a channel to 11 drops its level the next cycle. There is no pulse, and sticky is retained until cleared.
  - A mode change that makes d rise produces a pulse and sets sticky.
- Channels are fully independent. There is no priority between channels.

## Timing
- Reset (iReset=1 at a clock edge): shadow, active, ovLevel, ovPulse and ovSticky all go to 0, so oAny=0. iLoad, iUpdate and ivClear are ignored during reset.
- Reset mid-operation: all state is lost in the same edge. The first compare after reset uses active=0.
  - Consequence: mode 00 with ivCuenta=0 raises level and pulse 1 cycle after reset deasserts.
- Latency: inputs sampled at edge n appear on ovLevel/ovPulse/ovSticky after edge n (1 cycle).
- iUpdate at edge n: the new active value is used for the compare sampled at edge n+1. Outputs reflect it after edge n+1.
- Pulse width is exactly 1 cycle. A held match gives no second pulse. A match that drops and returns produces a new pulse.
- ivClear at edge n: sticky is 0 after edge n, unless a rising edge occurs at edge n.

## Test plan
- **Reset values:** iReset=1 for 2 cycles with random inputs -> all outputs 0. Then ivCuenta=5, mode 00 -> level stays 0 (active=0).
- **Double buffering:** iLoad with ch0=0x10; ivCuenta=0x10; no iUpdate -> ovLevel[0]=0. Then iUpdate -> ovLevel[0]=1 and ovPulse[0]=1 two edges after iUpdate, and ovPulse[0]=0 the cycle after.
- **Modes:** ch0..3 = 0x80 with modes 00/01/10/11, count 0x00..0xFF:
  - ch0 level only at 0x80
  - ch1 level for >= 0x80
  - ch2 level for < 0x80
  - ch3 level never
  - pulses: ch0 at 0x80, ch1 at 0x80, ch2 at 0x00.
- **Sticky and clear:**
  - After a ch1 pulse, ovSticky[1]=1 and oAny=1.
  - ivClear[1] with no match -> 0 next cycle, oAny=0.
  - ivClear[1] in the same cycle as a rising match -> stays 1.
- **Simultaneous iLoad and iUpdate:** ch2=0x33 with both asserted and ivCuenta=0x33 next cycle -> ovLevel[2]=1 one cycle later. A subsequent lone iUpdate leaves active=0x33.
- **Parametrisation:** WIDTH=12, CHANNELS=2, thresholds 0xFFF and 0x000 mode 00, count wraps 0xFFF->0x000 -> ch0 pulse then ch1 pulse on consecutive cycles.
